// File: rtl/imem_fetch_resp.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_resp
// Purpose  : Instruction-fetch responder. Reads the word at the current PC
//            over a req/ack memory port, presents it to decode, and holds
//            the PC register (o_stall) until decode takes the instruction.
//            A redirect (i_flush) never withdraws an in-flight request: the
//            read is allowed to finish and its data is thrown away.
// Ports    : i_clk, i_reset       - clock / synchronous active-high reset
//            i_pc                 - current PC from the PC register
//            i_flush              - redirect, PC loads a new target next edge
//            i_id_stall           - decode cannot accept this cycle
//            o_stall              - hold the PC register (combinational)
//            o_instr, o_instr_valid, o_instr_pc - instruction to decode
//            o_mem_req, o_mem_addr, i_mem_ack, i_mem_rdata - memory port
//            o_fetch_cnt          - instructions delivered to decode
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_resp #(
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          DATA_W    = 32,
  parameter logic [DATA_W-1:0]    NOP_INSTR = 32'h0000_0013
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_flush,
  input  logic              i_id_stall,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_instr,
  output logic              o_instr_valid,
  output logic [ADDR_W-1:0] o_instr_pc,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [31:0]       o_fetch_cnt
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t            state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] instr_q;
  logic              instr_valid_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [31:0]       fetch_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_ISSUE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
      fetch_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_ISSUE: begin
          // During a flush i_pc is about to be replaced, so wait for the
          // redirect target before issuing.
          if (!i_flush) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= {i_pc[ADDR_W-1:2], 2'b00};
            instr_pc_q <= i_pc;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_mem_ack) begin
            mem_req_q <= 1'b0;
            if (i_flush) begin
              state_q <= S_ISSUE;
            end else begin
              instr_q       <= i_mem_rdata;
              instr_valid_q <= 1'b1;
              state_q       <= S_VALID;
            end
          end else if (i_flush) begin
            // Request stays up; the eventual data is discarded in DROP.
            state_q <= S_DROP;
          end
        end
        S_VALID: begin
          // Flush takes priority over a simultaneous consume.
          if (i_flush) begin
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            state_q       <= S_ISSUE;
          end else if (!i_id_stall) begin
            instr_valid_q <= 1'b0;
            fetch_cnt_q   <= fetch_cnt_q + 32'd1;
            state_q       <= S_ISSUE;
          end
        end
        S_DROP: begin
          if (i_mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= S_ISSUE;
          end
        end
        default: state_q <= S_ISSUE;
      endcase
    end
  end

  // Flush always lets the PC load its redirect target; otherwise the PC
  // advances only on the cycle decode consumes the instruction.
  assign o_stall = i_reset |
                   (~i_flush & ~((state_q == S_VALID) & ~i_id_stall));

  assign o_instr       = instr_q;
  assign o_instr_valid = instr_valid_q;
  assign o_instr_pc    = instr_pc_q;
  assign o_mem_req     = mem_req_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_fetch_cnt   = fetch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_resp
// Purpose  : Self-checking bench for imem_fetch_resp. Each fetch is described
//            as a transaction (PC, memory latency, decode stall length,
//            optional redirect point) and the expected per-cycle outputs are
//            derived from that description; the bench also plays memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_resp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        i_id_stall;
  logic        o_stall;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic [31:0] o_instr_pc;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_fetch_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state: what decode should currently see and how many it took.
  logic [31:0] exp_instr;
  logic [31:0] exp_cnt;

  imem_fetch_resp dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_pc         (i_pc),
    .i_flush      (i_flush),
    .i_id_stall   (i_id_stall),
    .o_stall      (o_stall),
    .o_instr      (o_instr),
    .o_instr_valid(o_instr_valid),
    .o_instr_pc   (o_instr_pc),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_fetch_cnt  (o_fetch_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1 (tag, o_mem_req, 1'b0);
    chk32(tag, o_mem_addr, 32'h0);
    chk32(tag, o_instr, NOP);
    chk1 (tag, o_instr_valid, 1'b0);
    chk32(tag, o_instr_pc, 32'h0);
    chk32(tag, o_fetch_cnt, 32'h0);
  endtask

  // One fetch transaction, entered just after an edge with the DUT idle.
  //   n_iflush : flush cycles while idle before the real PC is presented
  //   lat      : cycles after the first request cycle until ack
  //   stall    : decode-stall cycles before consume
  //   mode     : 0 none, 1 flush on request cycle fat, 2 flush on valid cycle fat
  task automatic run_txn(input logic [31:0] pc, input int n_iflush, input int lat,
                         input int stall, input int mode, input int fat,
                         input logic [31:0] word);
    logic dropping;
    logic fl;
    logic consume;
    for (int i = 0; i < n_iflush; i++) begin
      i_pc       = $urandom;
      i_flush    = 1'b1;
      i_mem_ack  = 1'($urandom_range(0, 1));
      i_id_stall = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      chk1 ("iflush_req", o_mem_req, 1'b0);
      chk1 ("iflush_stall", o_stall, 1'b0);
      chk1 ("iflush_valid", o_instr_valid, 1'b0);
      tick();
    end

    // Idle cycle: ack is noise here and must be ignored.
    i_pc       = pc;
    i_flush    = 1'b0;
    i_mem_ack  = 1'($urandom_range(0, 1));
    i_id_stall = 1'($urandom_range(0, 1));
    @(negedge i_clk);
    chk1 ("issue_req", o_mem_req, 1'b0);
    chk1 ("issue_stall", o_stall, 1'b1);
    chk1 ("issue_valid", o_instr_valid, 1'b0);
    chk32("issue_instr", o_instr, exp_instr);
    chk32("issue_cnt", o_fetch_cnt, exp_cnt);
    tick();

    dropping = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      if (mode == 1 && k == fat) fl = 1'b1;
      else if (dropping)         fl = 1'($urandom_range(0, 1));
      else                       fl = 1'b0;
      i_flush     = fl;
      i_mem_ack   = (k == lat);
      i_mem_rdata = (k == lat) ? word : $urandom;
      i_id_stall  = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      chk1 ("req_req", o_mem_req, 1'b1);
      chk32("req_addr", o_mem_addr, {pc[31:2], 2'b00});
      chk32("req_pc", o_instr_pc, pc);
      chk1 ("req_valid", o_instr_valid, 1'b0);
      chk1 ("req_stall", o_stall, ~fl);
      chk32("req_instr", o_instr, exp_instr);
      if (fl) dropping = 1'b1;
      tick();
    end
    i_mem_ack = 1'b0;
    i_flush   = 1'b0;

    if (!dropping) begin
      exp_instr = word;
      for (int s = 0; ; s++) begin
        fl      = (mode == 2 && s == fat);
        consume = (s >= stall);
        i_flush    = fl;
        i_id_stall = ~consume;
        @(negedge i_clk);
        chk1 ("val_valid", o_instr_valid, 1'b1);
        chk32("val_instr", o_instr, word);
        chk32("val_pc", o_instr_pc, pc);
        chk1 ("val_req", o_mem_req, 1'b0);
        chk32("val_cnt", o_fetch_cnt, exp_cnt);
        chk1 ("val_stall", o_stall, ~(fl | consume));
        tick();
        if (fl) begin
          exp_instr = NOP;
          break;
        end
        if (consume) begin
          exp_cnt = exp_cnt + 32'd1;
          break;
        end
      end
      i_flush    = 1'b0;
      i_id_stall = 1'b0;
    end
  endtask

  // Start a fetch and hit it with reset while the request is outstanding.
  task automatic reset_mid_req(input logic [31:0] pc);
    i_pc = pc; i_flush = 1'b0; i_mem_ack = 1'b0;
    tick();
    @(negedge i_clk);
    chk1("mrst_req_up", o_mem_req, 1'b1);
    tick();
    i_reset = 1'b1;
    @(negedge i_clk);
    chk1("mrst_stall", o_stall, 1'b1);
    tick();
    i_reset = 1'b0;
    @(negedge i_clk);
    chk_reset_vals("mrst_vals");
    chk1("mrst_stall_after", o_stall, 1'b1);
    exp_instr = NOP;
    exp_cnt   = 32'h0;
    tick();
    // Cycle after reset was idle; one more idle-type cycle has now passed,
    // so the DUT has issued pc. Let that read complete and be consumed.
    i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678;
    @(negedge i_clk);
    chk32("mrst_reissue_addr", o_mem_addr, {pc[31:2], 2'b00});
    tick();
    i_mem_ack = 1'b0; i_id_stall = 1'b0;
    @(negedge i_clk);
    chk32("mrst_reissue_instr", o_instr, 32'h1234_5678);
    tick();
    exp_instr = 32'h1234_5678;
    exp_cnt   = 32'h1;
  endtask

  initial begin
    i_reset = 1'b1; i_pc = 32'h0; i_flush = 1'b1; i_id_stall = 1'b0;
    i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
    exp_instr = NOP;
    exp_cnt   = 32'h0;
    tick();
    @(negedge i_clk);
    chk1("rst_stall_over_flush", o_stall, 1'b1);
    chk_reset_vals("rst_vals");
    tick();
    i_reset = 1'b0;
    i_flush = 1'b0;

    // Back-to-back minimum-latency fetch.
    run_txn(32'h0000_0000, 0, 0, 0, 0, 0, 32'h0050_0093);
    // Slow memory.
    run_txn(32'h0000_0104, 0, 4, 0, 0, 0, $urandom);
    // Decode stalls three cycles.
    run_txn(32'h0000_0008, 0, 0, 3, 0, 0, $urandom);
    // Flush before ack: data discarded, then refetch from redirect target.
    run_txn(32'h0000_0010, 0, 2, 0, 1, 0, 32'hDEAD_BEEF);
    run_txn(32'h0000_0200, 0, 1, 0, 0, 0, $urandom);
    // Flush and consume in the same valid cycle.
    run_txn(32'h0000_0020, 0, 0, 2, 2, 2, $urandom);
    // Unaligned PC.
    run_txn(32'h0000_0103, 0, 0, 0, 0, 0, $urandom);
    // Flushes while idle, then flush coinciding with ack.
    run_txn(32'h0000_0300, 2, 2, 0, 1, 2, $urandom);
    // Flush while decode is stalled.
    run_txn(32'h0000_0400, 0, 1, 3, 2, 1, $urandom);

    reset_mid_req(32'h0000_0abc);

    for (int t = 0; t < 120; t++) begin
      int lat, stall, mode, fat;
      lat   = int'($urandom_range(0, 4));
      stall = int'($urandom_range(0, 3));
      mode  = int'($urandom_range(0, 2));
      fat   = (mode == 1) ? int'($urandom_range(0, lat)) : int'($urandom_range(0, stall + 1));
      run_txn($urandom, int'($urandom_range(0, 1)), lat, stall, mode, fat, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_fetch_resp.md
Name: imem_fetch_resp

Overview:
- Instruction-fetch responder at the far end of the program-counter register.
- Takes the current PC, runs a req/ack read on instruction memory, and presents the fetched word to the decode stage.
- Drives the stall input of the PC register, so the PC advances only when an instruction has been handed to decode.
- Handles branch/jump redirect (flush) while a memory read is in flight, without violating the memory protocol.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction word width.
- NOP_INSTR, 32'h0000_0013, value on o_instr at reset and after flush (RISC-V addi x0,x0,0).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_pc  in  ADDR_W  current PC from the PC register.
- i_flush  in  1  redirect; PC register loads a new target at the next edge.
- i_id_stall  in  1  decode cannot accept an instruction this cycle.
- o_stall  out  1  to PC register; 1 = hold PC.
- o_instr  out  DATA_W  fetched instruction.
- o_instr_valid  out  1  o_instr is valid for decode.
- o_instr_pc  out  ADDR_W  PC of o_instr.
- o_mem_req  out  1  memory read request.
- o_mem_addr  out  ADDR_W  word-aligned read address.
- i_mem_ack  in  1  memory read complete; i_mem_rdata valid this cycle.
- i_mem_rdata  in  DATA_W  read data.
- o_fetch_cnt  out  32  count of instructions delivered to decode.

Behaviour:
- Registers, updated on rising i_clk: state, o_mem_req, o_mem_addr, o_instr, o_instr_valid, o_instr_pc, o_fetch_cnt. o_stall is combinational.
- Reset (i_reset=1 at an edge, overrides everything, any state):
  - state=ISSUE, o_mem_req=0, o_mem_addr=0, o_instr=NOP_INSTR, o_instr_valid=0, o_instr_pc=0, o_fetch_cnt=0.
  - o_stall=1 while i_reset=1.
  - A reset arriving mid-read abandons the read; memory is reset with the same signal.
- Memory protocol:
  - Once o_mem_req=1, o_mem_req and o_mem_addr are held stable until a cycle with i_mem_ack=1.
  - o_mem_req drops on the edge after that ack.
  - Ack may arrive in the first cycle o_mem_req=1.
  - i_mem_ack is ignored when o_mem_req=0.
  - The request is never withdrawn early, including on flush.
- o_mem_addr = {i_pc[ADDR_W-1:2],2'b00}, latched from i_pc.
- States:
  - ISSUE: o_mem_req=0.
    - Next edge: latch addr and o_instr_pc=i_pc, o_mem_req=1, go to REQ.
    - If i_flush=1, stay in ISSUE (i_pc is about to change).
  - REQ: waiting for ack.
    - ack=1, flush=0: o_instr=i_mem_rdata, o_instr_valid=1, o_mem_req=0, go to VALID.
    - ack=1, flush=1: discard data, o_mem_req=0, go to ISSUE.
    - ack=0, flush=1: go to DROP.
    - ack=0, flush=0: stay in REQ.
  - VALID: o_instr_valid=1, held stable while i_id_stall=1.
    - i_id_stall=0 (consume): o_fetch_cnt+=1 (wraps at 2^32), o_instr_valid=0, go to ISSUE.
    - i_flush=1: o_instr_valid=0, o_instr=NOP_INSTR, no count, go to ISSUE. Flush wins over consume.
  - DROP: o_mem_req=1, addr held.
    - On ack: discard data, o_mem_req=0, go to ISSUE.
    - Further flushes keep the block in DROP.
- o_stall = i_reset | (~i_flush & ~(state==VALID & ~i_id_stall)).
  - Flush always releases the PC so the redirect target loads.
  - Otherwise the PC advances exactly on the consume cycle.
- Timing:
  - Minimum 3 cycles per instruction: ISSUE, REQ with same-cycle ack, VALID consumed.
  - Memory latency of L cycles after the first request cycle adds L cycles.
- Invariants:
  - o_instr_valid=1 only in VALID.
  - o_mem_req=1 only in REQ or DROP.
  - A single outstanding read at most.

Test Plan:
- Reset then i_pc=0x0, memory acks on the first req cycle with 0x00500093 -> req/addr 0x0 at cycle 1, o_instr_valid=1 with o_instr=0x00500093 at cycle 2, o_stall=0 at cycle 2 only, o_fetch_cnt=1 at cycle 3.
- i_pc=0x104, ack delayed 4 cycles -> o_mem_req and o_mem_addr=0x104 stable for 5 cycles, o_stall=1 throughout, instruction delivered with o_instr_pc=0x104.
- VALID with i_id_stall=1 for 3 cycles -> o_instr and o_instr_valid stable, o_stall=1, o_fetch_cnt unchanged; consumed on the 4th cycle.
- i_flush in REQ before ack, ack 2 cycles later with 0xDEADBEEF -> DROP, o_mem_req held until ack, data never appears, o_instr_valid=0, next request uses the new i_pc=0x200.
- Flush and consume in the same VALID cycle -> o_instr_valid=0, o_instr=NOP_INSTR, o_fetch_cnt unchanged, o_stall=0; plus i_reset=1 asserted mid-REQ -> next edge all outputs at reset values.
- i_pc=0x103 -> o_mem_addr=0x100, o_instr_pc=0x103; o_fetch_cnt preset near 0xFFFFFFFF by driving consumes wraps to 0.
